// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the three-requester memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  // Requester ids; also bit positions in gnt/rvalid.
  localparam logic [1:0] REQ_F = 2'd0;
  localparam logic [1:0] REQ_D = 2'd1;
  localparam logic [1:0] REQ_L = 2'd2;

  // (base + step) mod 3, for base in 0..2 and step in 0..3.
  function automatic logic [1:0] rr_step(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, step};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Requester id to its one-hot {l,d,f} position.
  function automatic logic [2:0] onehot3(input logic [1:0] id);
    return 3'b001 << id;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          l_req;
  logic          l_lock;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [2:0]    gnt;
  logic [2:0]    rvalid;
  logic [DW-1:0] rdata;
  logic [1:0]    owner;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Requesters plus the memory: drive requests and read data.
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
           l_req, l_lock, l_we, l_addr, l_wdata, mem_rdata,
    input  gnt, rvalid, rdata, owner, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  // The arbiter itself.
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
           l_req, l_lock, l_we, l_addr, l_wdata, mem_rdata,
    output gnt, rvalid, rdata, owner, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker with an override id.
import mem_port_arbiter_pkg::*;

module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  input  logic [1:0] force_id,
  input  logic       force_en,
  output logic [1:0] win,
  output logic       any
);
  logic [1:0] cand;
  logic       found;

  // Search starts one past the last owner; the override wins outright.
  always_comb begin
    any   = |req;
    win   = last;
    cand  = 2'd0;
    found = 1'b0;
    if (force_en) begin
      win = force_id;
    end else begin
      for (int i = 1; i <= 3; i++) begin
        cand = rr_step(last, 2'(i));
        if (!found && req[cand]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 1-cycle-latency synchronous RAM between fetch, data and loader
// requesters: round-robin with a bounded loader burst lock, one access per 2 cycles.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int BURST_MAX = 4
) (
  input logic            clk,
  input logic            reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(BURST_MAX + 1);

  arb_state_e    state;
  logic [1:0]    owner_q;
  logic [CW-1:0] burst_cnt;
  logic [2:0]    gnt_q, rvalid_q;
  logic          busy_q, mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic [2:0]    req;
  logic [1:0]    win;
  logic          any, lock_en;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign req     = {bus.l_req, bus.d_req, bus.f_req};
  // Loader keeps the port while it owns it, holds lock, and has burst budget left.
  assign lock_en = (owner_q == REQ_L) && bus.l_req && bus.l_lock &&
                   (burst_cnt < CW'(BURST_MAX));

  rr_pick3 u_pick (
    .req      (req),
    .last     (owner_q),
    .force_id (REQ_L),
    .force_en (lock_en),
    .win      (win),
    .any      (any)
  );

  // Route the winner's command fields toward the memory registers.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = bus.f_addr;
    sel_wdata = '0;
    case (win)
      REQ_D: begin
        sel_we    = bus.d_we;
        sel_addr  = bus.d_addr;
        sel_wdata = bus.d_wdata;
      end
      REQ_L: begin
        sel_we    = bus.l_we;
        sel_addr  = bus.l_addr;
        sel_wdata = bus.l_wdata;
      end
      default: ;
    endcase
  end

  // Arbitration FSM; all outputs registered, reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARB_IDLE;
      owner_q     <= REQ_L;
      burst_cnt   <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state)
        ARB_IDLE, ARB_RESP: begin
          if (any) begin
            state       <= ARB_ISSUE;
            busy_q      <= 1'b1;
            owner_q     <= win;
            gnt_q       <= onehot3(win);
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            // Saturate so a lone loader past its budget cannot wrap back into lock.
            if (win == REQ_L)
              burst_cnt <= (burst_cnt == CW'(BURST_MAX)) ? burst_cnt : burst_cnt + CW'(1);
            else
              burst_cnt <= '0;
          end else begin
            state     <= ARB_IDLE;
            busy_q    <= 1'b0;
            burst_cnt <= '0;
          end
        end
        ARB_ISSUE: begin
          state    <= ARB_RESP;
          rvalid_q <= onehot3(owner_q);
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  // RAM output is valid exactly in the completion cycle; pass it straight through.
  assign bus.rdata     = (|rvalid_q) ? bus.mem_rdata : '0;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle-latency RAM model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.AW(8), .DW(16)) bus ();

  mem_port_arbiter #(.AW(8), .DW(16), .BURST_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model plus a bench-side preload port.
  logic [15:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.f_req = 0; bus.f_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.l_req = 0; bus.l_lock = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0;
  endtask

  task automatic do_reset();
    clear_reqs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++;
    if ({bus.gnt, bus.rvalid, bus.rdata, bus.mem_en, bus.mem_we, bus.mem_addr,
         bus.mem_wdata, bus.busy, bus.owner} !== {3'b0, 3'b0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL reset_init got gnt=%b rv=%b en=%b busy=%b owner=%0d", bus.gnt, bus.rvalid,
               bus.mem_en, bus.busy, bus.owner);
    end
    do_reset();
    // Fetch in flight, then reset in its completion cycle.
    bus.f_req = 1; bus.f_addr = 8'h33;
    tick();
    bus.f_req = 0;
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.gnt, bus.rvalid, bus.rdata, bus.mem_en, bus.mem_we, bus.mem_addr,
         bus.mem_wdata, bus.busy, bus.owner} !== {3'b0, 3'b0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL reset_midrun got gnt=%b rv=%b en=%b addr=%h busy=%b owner=%0d", bus.gnt,
               bus.rvalid, bus.mem_en, bus.mem_addr, bus.busy, bus.owner);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    pre_we = 1; pre_addr = 8'h10; pre_data = 16'hABCD;
    tick();
    pre_we = 0;
    do_reset();
    bus.f_req = 1; bus.f_addr = 8'h10;
    tick();
    checks++;
    if ({bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.busy} !== {3'b001, 1'b1, 1'b0, 8'h10, 1'b1}) begin
      errors++;
      $display("FAIL fetch_issue got gnt=%b en=%b we=%b addr=%h busy=%b exp 001 1 0 10 1",
               bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.busy);
    end
    bus.f_req = 0;
    tick();
    checks++;
    if ({bus.rvalid, bus.rdata, bus.gnt, bus.mem_en} !== {3'b001, 16'hABCD, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL fetch_resp got rv=%b rdata=%h gnt=%b en=%b exp 001 abcd 000 0",
               bus.rvalid, bus.rdata, bus.gnt, bus.mem_en);
    end
    tick();
    checks++;
    if ({bus.rvalid, bus.busy, bus.owner} !== {3'b000, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL fetch_idle got rv=%b busy=%b owner=%0d exp 000 0 0", bus.rvalid, bus.busy, bus.owner);
    end
  endtask

  task automatic test_store_load();
    do_reset();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h20; bus.d_wdata = 16'h1234;
    tick();
    checks++;
    if ({bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b010, 1'b1, 1'b1, 8'h20, 16'h1234}) begin
      errors++;
      $display("FAIL store_issue got gnt=%b en=%b we=%b addr=%h wd=%h exp 010 1 1 20 1234",
               bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.d_req = 0;
    tick();
    checks++;
    if (bus.rvalid !== 3'b010) begin
      errors++;
      $display("FAIL store_ack got rv=%b exp 010", bus.rvalid);
    end
    tick();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h20; bus.d_wdata = 16'hFFFF;
    tick();
    checks++;
    if ({bus.gnt, bus.mem_we, bus.mem_addr, bus.owner} !== {3'b010, 1'b0, 8'h20, 2'd1}) begin
      errors++;
      $display("FAIL load_issue got gnt=%b we=%b addr=%h owner=%0d exp 010 0 20 1",
               bus.gnt, bus.mem_we, bus.mem_addr, bus.owner);
    end
    bus.d_req = 0;
    tick();
    checks++;
    if ({bus.rvalid, bus.rdata} !== {3'b010, 16'h1234}) begin
      errors++;
      $display("FAIL load_resp got rv=%b rdata=%h exp 010 1234", bus.rvalid, bus.rdata);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [6];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    bus.f_req = 1; bus.f_addr = 8'h01;
    bus.d_req = 1; bus.d_addr = 8'h02;
    bus.l_req = 1; bus.l_addr = 8'h03;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.gnt !== exp_g[i]) begin
        errors++;
        $display("FAIL rr_gnt[%0d] got %b exp %b", i, bus.gnt, exp_g[i]);
      end
      tick();
    end
    clear_reqs();
    tick();
    tick();
  endtask

  task automatic test_lock();
    logic [2:0] exp_g [6];
    exp_g = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b100};
    do_reset();
    bus.l_req = 1; bus.l_lock = 1; bus.l_we = 1; bus.l_addr = 8'h40; bus.l_wdata = 16'h5555;
    bus.d_req = 1; bus.d_addr = 8'h41;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.gnt !== exp_g[i]) begin
        errors++;
        $display("FAIL lock_gnt[%0d] got %b exp %b", i, bus.gnt, exp_g[i]);
      end
      tick();
    end
    clear_reqs();
    tick();
    tick();
  endtask

  task automatic test_reset_issue();
    do_reset();
    bus.f_req = 1; bus.f_addr = 8'h05;
    tick();
    bus.f_req = 0;
    tick();
    tick();
    // Owner is now fetch, so data is next in rotation.
    bus.f_req = 1; bus.d_req = 1; bus.d_addr = 8'h06;
    tick();
    checks++;
    if ({bus.gnt, bus.mem_en} !== {3'b010, 1'b1}) begin
      errors++;
      $display("FAIL rst_issue_pre got gnt=%b en=%b exp 010 1", bus.gnt, bus.mem_en);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.gnt, bus.mem_en, bus.busy, bus.owner} !== {3'b000, 1'b0, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL rst_issue_drop got gnt=%b en=%b busy=%b owner=%0d exp 000 0 0 2",
               bus.gnt, bus.mem_en, bus.busy, bus.owner);
    end
    tick();
    checks++;
    if (bus.rvalid !== 3'b000) begin
      errors++;
      $display("FAIL rst_issue_norv got rv=%b exp 000", bus.rvalid);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 3'b001) begin
      errors++;
      $display("FAIL rst_issue_first got gnt=%b exp 001", bus.gnt);
    end
    clear_reqs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_round_robin();
    test_lock();
    test_reset_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
